// File: rtl/bit_scan_pkg.sv
// Shared types and constants for the bit scan engine.
package bit_scan_pkg;

    // Default operand width for the scan engine.
    localparam int DEFAULT_DATA_W = 8;

    // Scan modes as encoded on the mode input. The encoding 2'b11 is folded onto ones counting.
    typedef enum logic [1:0] {
        MODE_ONES  = 2'b00,
        MODE_ZEROS = 2'b01,
        MODE_LZC   = 2'b10
    } scan_mode_t;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Map the raw mode input onto a scan mode. The unused encoding 2'b11 maps to ones counting.
    function automatic scan_mode_t map_mode(input logic [1:0] raw);
        scan_mode_t m;
        case (raw)
            2'b01:   m = MODE_ZEROS;
            2'b10:   m = MODE_LZC;
            default: m = MODE_ONES;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bit_scan_dp.sv
// Datapath for the bit scan engine. It holds the shift register, the result counter and the
// bits-left counter. It reports the termination condition and the current MSB to the controller.
module bit_scan_dp
    import bit_scan_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              inc_i,
    input  scan_mode_t        mode_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              term_o,
    output logic              msb_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] r1_q, r1_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  bits_left_q, bits_left_d;
    logic              fill_bit;
    logic              value_term;

    // Datapath registers; reset clears every register and abandons any scan in progress.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r1_q        <= '0;
            count_q     <= '0;
            bits_left_q <= '0;
        end else begin
            r1_q        <= r1_d;
            count_q     <= count_d;
            bits_left_q <= bits_left_d;
        end
    end

    // Load or shift-and-count. Zeros mode shifts in ones, so the all-ones test stays exact once
    // the real bits are consumed. The other modes shift in zeros.
    always_comb begin
        r1_d        = r1_q;
        count_d     = count_q;
        bits_left_d = bits_left_q;
        fill_bit    = (mode_i == MODE_ZEROS);
        if (load_i) begin
            r1_d        = data_i;
            count_d     = '0;
            bits_left_d = CNT_W'(DATA_W);
        end else if (shift_i) begin
            r1_d        = {r1_q[DATA_W-2:0], fill_bit};
            bits_left_d = bits_left_q - 1'b1;
            if (inc_i) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Early exit: nothing left that could change the count, or every bit has been consumed.
    always_comb begin
        case (mode_i)
            MODE_ZEROS: value_term = (r1_q == '1);
            MODE_LZC:   value_term = r1_q[DATA_W-1];
            default:    value_term = (r1_q == '0);
        endcase
        term_o = value_term || (bits_left_q == '0);
    end

    assign msb_o   = r1_q[DATA_W-1];
    assign count_o = count_q;

endmodule

// File: rtl/bit_scan_unit.sv
// Self-sequencing bit scan engine. It counts ones or zeros, or computes the leading-zero count,
// of a loaded word by shifting it out MSB-first. The controller FSM lives here and drives
// load, shift and increment strobes into bit_scan_dp.
module bit_scan_unit
    import bit_scan_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count
);

    state_t     state_q, state_d;
    scan_mode_t mode_q, mode_d;
    logic       load_s;
    logic       shift_s;
    logic       inc_s;
    logic       dp_term;
    logic       dp_msb;

    // State register, plus the mode captured with the accepted start.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            mode_q  <= MODE_ONES;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic. The termination check takes priority over shifting. Start is only
    // honoured in IDLE.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    mode_d  = map_mode(mode);
                end
            end
            SHIFT: begin
                if (dp_term) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and strobe decode. The increment depends on the mode and on the bit being shifted out.
    always_comb begin
        load_s  = (state_q == IDLE) && start;
        shift_s = (state_q == SHIFT) && !dp_term;
        case (mode_q)
            MODE_ZEROS: inc_s = !dp_msb;
            MODE_LZC:   inc_s = 1'b1;
            default:    inc_s = dp_msb;
        endcase
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    bit_scan_dp #(
        .DATA_W (DATA_W)
    ) u_dp (
        .clk     (clk),
        .rst_b   (rst_b),
        .load_i  (load_s),
        .shift_i (shift_s),
        .inc_i   (inc_s),
        .mode_i  (mode_q),
        .data_i  (data_in),
        .term_o  (dp_term),
        .msb_o   (dp_msb),
        .count_o (count)
    );

endmodule
